// File: rtl/uart_tx_async_rst.sv
// UART-style transmitter: valid/ready word in, start + LSB-first data + optional
// even parity + stop bit(s) out on tx_serial. Async active-high reset throughout.
module uart_tx_async_rst #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              async_reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_async_rst: DATA_W must be in 5..9");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
    $error("uart_tx_async_rst: CLKS_PER_BIT must be >= 1");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_async_rst: STOP_BITS must be 1 or 2");
  end

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = 4;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              serial_d, ready_d, busy_d, done_d;
  logic              bit_end;

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_serial <= serial_d;
      tx_ready  <= ready_d;
      tx_busy   <= busy_d;
      tx_done   <= done_d;
    end
  end

  // Counter counts down to zero then reloads, so CLKS_PER_BIT=1 gives a one-cycle bit.
  assign bit_end = (cyc_q == '0);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      cyc_d = bit_end ? RELOAD : cyc_q - CW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d = tx_data;
          par_d   = ^tx_data;
          cyc_d   = RELOAD;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_W - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they align with it.
  always_comb begin
    serial_d = 1'b1;
    unique case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
      S_PARITY: serial_d = par_d;
      default:  serial_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_async_rst.sv
// Bench for uart_tx_async_rst: four parameterisations driven from one directed
// sequence, line checked cycle by cycle against a frame-level bit model.
module tb_uart_tx_async_rst;

  logic            clk = 1'b0;
  logic            async_reset;
  logic [3:0]      vld;
  logic [3:0][8:0] dat;
  logic [3:0]      ser, rdy, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-instance configuration: DATA_W, CLKS_PER_BIT, PARITY_EN, STOP_BITS.
  int dw_t  [4] = '{8, 8, 8, 5};
  int cpb_t [4] = '{4, 2, 1, 1};
  int pen_t [4] = '{0, 1, 0, 0};
  int sb_t  [4] = '{1, 2, 1, 1};

  always #5 clk = ~clk;

  uart_tx_async_rst #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_a (
    .clk(clk), .async_reset(async_reset), .tx_data(dat[0][7:0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx_serial(ser[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_async_rst #(.DATA_W(8), .CLKS_PER_BIT(2), .PARITY_EN(1), .STOP_BITS(2)) u_b (
    .clk(clk), .async_reset(async_reset), .tx_data(dat[1][7:0]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx_serial(ser[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_async_rst #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .STOP_BITS(1)) u_c (
    .clk(clk), .async_reset(async_reset), .tx_data(dat[2][7:0]), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .tx_serial(ser[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_async_rst #(.DATA_W(5), .CLKS_PER_BIT(1), .PARITY_EN(0), .STOP_BITS(1)) u_d (
    .clk(clk), .async_reset(async_reset), .tx_data(dat[3][4:0]), .tx_valid(vld[3]),
    .tx_ready(rdy[3]), .tx_serial(ser[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  task automatic chk(input string tag, input int idx, input int cyc,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d cycle %0d observed %0h expected %0h", tag, idx, cyc, obs, exp);
    end
  endtask

  function automatic int frame_len(input int idx);
    return (1 + dw_t[idx] + pen_t[idx] + sb_t[idx]) * cpb_t[idx];
  endfunction

  function automatic logic even_par(input int idx, input logic [8:0] d);
    logic p = 1'b0;
    for (int i = 0; i < dw_t[idx]; i++) p = p ^ d[i];
    return p;
  endfunction

  // Line level in cycle c (1..F) after the accept edge.
  function automatic logic exp_line(input int idx, input logic [8:0] d, input int c);
    int b = (c - 1) / cpb_t[idx];
    if (b == 0) return 1'b0;
    if (b <= dw_t[idx]) return d[b-1];
    if (pen_t[idx] != 0 && b == dw_t[idx] + 1) return even_par(idx, d);
    return 1'b1;
  endfunction

  task automatic check_idle(input string tag, input int idx, input int cyc);
    chk({tag, "_serial"}, idx, cyc, ser[idx], 1);
    chk({tag, "_ready"},  idx, cyc, rdy[idx], 1);
    chk({tag, "_busy"},   idx, cyc, busy[idx], 0);
    chk({tag, "_done"},   idx, cyc, done[idx], 0);
  endtask

  // Called at the falling edge of cycle 0; returns at the falling edge of cycle 1.
  task automatic present(input int idx, input logic [8:0] d);
    vld[idx] = 1'b1;
    dat[idx] = d;
    chk("accept_ready", idx, 0, rdy[idx], 1);
    @(negedge clk);
  endtask

  // Checks cycles 1..F+1; returns at the falling edge of cycle F+1. With chain set,
  // tx_valid stays high and tx_data switches to nd so it is taken at the F+1 edge.
  task automatic check_frame(input int idx, input logic [8:0] d, input bit chain,
                             input logic [8:0] nd);
    int f = frame_len(idx);
    for (int c = 1; c <= f + 1; c++) begin
      if (chain) dat[idx] = nd;
      else begin
        vld[idx] = 1'b0;
        dat[idx] = 9'($urandom);
      end
      chk("serial", idx, c, ser[idx], (c <= f) ? exp_line(idx, d, c) : 1'b1);
      chk("busy",   idx, c, busy[idx], (c <= f) ? 1 : 0);
      chk("ready",  idx, c, rdy[idx],  (c <= f) ? 0 : 1);
      chk("done",   idx, c, done[idx], (c == f + 1) ? 1 : 0);
      if (c <= f) @(negedge clk);
    end
  endtask

  task automatic send(input int idx, input logic [8:0] d);
    present(idx, d);
    check_frame(idx, d, 1'b0, '0);
    @(negedge clk);
    check_idle("post_frame", idx, frame_len(idx) + 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    async_reset = 1'b1;
    vld = '0;
    dat = '0;
    #1;
    for (int i = 0; i < 4; i++) check_idle("reset", i, 0);
    repeat (2) @(negedge clk);
    async_reset = 1'b0;
    @(negedge clk);

    // Basic frame, CLKS_PER_BIT=4
    send(0, 9'h0A5);
    // Parity and two stop bits
    send(1, 9'h007);
    send(1, 9'h003);

    // tx_valid held high: second word taken only at the F+1 edge
    present(2, 9'h011);
    check_frame(2, 9'h011, 1'b1, 9'h022);
    @(negedge clk);
    check_frame(2, 9'h022, 1'b0, '0);
    @(negedge clk);
    check_idle("chain_end", 2, 0);

    // Reset pulse part way through a frame
    present(0, 9'h05A);
    vld[0] = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_reset_busy",   0, 15, busy[0], 1);
    chk("pre_reset_serial", 0, 15, ser[0], exp_line(0, 9'h05A, 15));
    #2 async_reset = 1'b1;
    #1;
    check_idle("mid_reset", 0, 15);
    @(negedge clk);
    async_reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check_idle("after_reset", 0, c);
      @(negedge clk);
    end
    send(0, 9'h0FF);

    // DATA_W=5, one cycle per bit
    send(3, 9'h015);

    // Long idle with tx_valid low
    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < 4; i++) check_idle("idle", i, c);
      @(negedge clk);
    end

    // Random words and gaps (gap 0 exercises back-to-back acceptance)
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 6; k++) begin
        logic [8:0] d;
        int gap;
        d   = 9'($urandom) & 9'((1 << dw_t[i]) - 1);
        gap = int'($urandom_range(0, 2));
        present(i, d);
        check_frame(i, d, 1'b0, '0);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check_idle("gap", i, g);
        end
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
